aes192_job_arbiter: RTL and testbench

- Shares one AES-192 engine (aes_192_sed-style: level start, 128b p_c_text/state, 192b key, 128b out, out_valid) between NUM_REQ hardware requesters.
- Round-robin grant, per-requester key-slot permission check, engine sequencing (start/valid handshake with drain and timeout), single tagged response channel.
- Sits between the SoC crypto clients and the engine; the three key slots stay programmed through the existing register wrapper.

---
 rtl/aes192_job_arbiter_pkg.sv | 30 +++
 rtl/aes192_job_arbiter_if.sv | 30 +++
 rtl/aes192_job_arbiter_rr_arbiter.sv | 36 +++
 rtl/aes192_job_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_aes192_job_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes192_job_arbiter_pkg.sv
// Shared types for the AES-192 job arbiter.
// State encoding, response error codes and key-slot ids.
package aes_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_PERM    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } rsp_err_t;

  localparam logic [1:0] KEY_SLOT0 = 2'd0;
  localparam logic [1:0] KEY_SLOT1 = 2'd1;
  localparam logic [1:0] KEY_SLOT2 = 2'd2;
  localparam int NUM_KEY_SLOTS = 3;

  // Slot encoding 3 has no key of its own and aliases slot 2.
  function automatic logic [1:0] norm_slot(
    input logic [1:0] sel
  );
    return (sel == 2'd3) ? KEY_SLOT2 : sel;
  endfunction

endpackage

// File: rtl/aes192_job_arbiter_if.sv
// Engine-side bus between the job arbiter and one AES-192 core.
// Names follow the arbiter's point of view.
interface aes192_job_arbiter_if;

  logic         aes_start_o;
  logic [127:0] aes_pt_o;
  logic [127:0] aes_state_o;
  logic [1:0]   aes_key_sel_o;
  logic [127:0] aes_ct_i;
  logic         aes_valid_i;

  modport master (
    output aes_start_o,
    output aes_pt_o,
    output aes_state_o,
    output aes_key_sel_o,
    input  aes_ct_i,
    input  aes_valid_i
  );

  modport slave (
    input  aes_start_o,
    input  aes_pt_o,
    input  aes_state_o,
    input  aes_key_sel_o,
    output aes_ct_i,
    output aes_valid_i
  );

endinterface

// File: rtl/aes192_job_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after ptr.
// Reusable for any shared crypto engine.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_hi;
  logic [N-1:0] w_src;

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N; i++) begin
      w_hi[i] = i_req[i] && (i > int'(i_ptr));
    end
    // Requests above ptr win; otherwise wrap to the bottom.
    w_src = (|w_hi) ? w_hi : i_req;
    o_idx = '0;
    o_gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        o_idx    = IW'(i);
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/aes192_job_arbiter.sv
// Shares one AES-192 engine between NUM_REQ requesters with
// key-slot permission checks, stale-result drain and timeout.
module aes192_job_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*128-1:0] req_pt_i,
  input  logic [NUM_REQ*128-1:0] req_state_i,
  input  logic [NUM_REQ*2-1:0]   req_key_sel_i,
  input  logic [NUM_REQ*3-1:0]   key_perm_i,
  aes192_job_arbiter_if.master   eng,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [127:0]           rsp_ct_o,
  output logic [1:0]             rsp_err_o,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t r_state;
  arb_state_t w_nxt;

  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [127:0]     r_pt;
  logic [127:0]     r_st;
  logic [1:0]       r_key;
  logic [127:0]     r_aes_pt;
  logic [127:0]     r_aes_st;
  logic [1:0]       r_aes_key;
  logic [CNT_W-1:0] r_cnt;
  logic [127:0]     r_ct;
  logic [1:0]       r_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [127:0]       w_sel_pt;
  logic [127:0]       w_sel_st;
  logic [1:0]         w_sel_key;
  logic [2:0]         w_perm_row;
  logic               w_perm;
  logic               w_expire;

  logic w_cap;
  logic w_deny;
  logic w_load;
  logic w_ok;
  logic w_tmo;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel_pt   = '0;
    w_sel_st   = '0;
    w_sel_key  = KEY_SLOT0;
    w_perm_row = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_pt   = req_pt_i[i*128 +: 128];
        w_sel_st   = req_state_i[i*128 +: 128];
        w_sel_key  = norm_slot(req_key_sel_i[i*2 +: 2]);
        w_perm_row = key_perm_i[i*3 +: 3];
      end
    end
    unique case (w_sel_key)
      KEY_SLOT0: w_perm = w_perm_row[0];
      KEY_SLOT1: w_perm = w_perm_row[1];
      default:   w_perm = w_perm_row[2];
    endcase
  end

  assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_nxt  = r_state;
    w_cap  = 1'b0;
    w_deny = 1'b0;
    w_load = 1'b0;
    w_ok   = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_cap = 1'b1;
          if (w_perm) begin
            w_nxt = DRAIN;
          end else begin
            w_nxt  = RESP;
            w_deny = 1'b1;
          end
        end
      end
      DRAIN: begin
        // A result left over from the last job must clear first.
        if (!eng.aes_valid_i) begin
          w_nxt  = RUN;
          w_load = 1'b1;
        end
      end
      RUN: begin
        if (eng.aes_valid_i) begin
          w_nxt = RESP;
          w_ok  = 1'b1;
        end else if (w_expire) begin
          w_nxt = RESP;
          w_tmo = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_ptr     <= ID_W'(NUM_REQ - 1);
      r_id      <= '0;
      r_pt      <= '0;
      r_st      <= '0;
      r_key     <= '0;
      r_aes_pt  <= '0;
      r_aes_st  <= '0;
      r_aes_key <= '0;
      r_cnt     <= '0;
      r_ct      <= '0;
      r_err     <= ERR_OK;
    end else begin
      r_state <= w_nxt;
      if (w_cap) begin
        r_pt  <= w_sel_pt;
        r_st  <= w_sel_st;
        r_key <= w_sel_key;
        r_id  <= w_idx;
        r_ptr <= w_idx;
      end
      if (w_deny) begin
        r_ct  <= '0;
        r_err <= ERR_PERM;
      end
      // Engine inputs only change on the way into RUN.
      if (w_load) begin
        r_aes_pt  <= r_pt;
        r_aes_st  <= r_st;
        r_aes_key <= r_key;
        r_cnt     <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ok) begin
        r_ct  <= eng.aes_ct_i;
        r_err <= ERR_OK;
      end
      if (w_tmo) begin
        r_ct  <= '0;
        r_err <= ERR_TIMEOUT;
      end
    end
  end

  assign req_ready_o = (r_state == IDLE && !rst_i) ? w_gnt : '0;

  assign eng.aes_start_o   = (r_state == RUN);
  assign eng.aes_pt_o      = r_aes_pt;
  assign eng.aes_state_o   = r_aes_st;
  assign eng.aes_key_sel_o = r_aes_key;

  assign rsp_valid_o = (r_state == RESP);
  assign rsp_id_o    = r_id;
  assign rsp_ct_o    = r_ct;
  assign rsp_err_o   = r_err;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_aes192_job_arbiter.sv
// Bench for aes192_job_arbiter: engine model plus response scoreboard.
// Scenario tasks run in sequence from one initial block.
module tb_aes192_job_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;
  localparam int L  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_pt    = '0;
  logic [N*128-1:0] req_state = '0;
  logic [N*2-1:0]   req_key   = '0;
  logic [N*3-1:0]   perm      = '1;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IW-1:0]    rsp_id;
  logic [127:0]     rsp_ct;
  logic [1:0]       rsp_err;
  logic             busy;

  aes192_job_arbiter_if eng();

  aes192_job_arbiter #(
    .NUM_REQ        (N),
    .ID_W           (IW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_pt_i      (req_pt),
    .req_state_i   (req_state),
    .req_key_sel_i (req_key),
    .key_perm_i    (perm),
    .eng           (eng.master),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_id_o      (rsp_id),
    .rsp_ct_o      (rsp_ct),
    .rsp_err_o     (rsp_err),
    .busy_o        (busy)
  );

  // Engine model: out = pt ^ state, valid L cycles after start rises.
  int m_cnt  = 0;
  int m_hold = 0;
  bit m_en    = 1'b1;
  bit m_stale = 1'b0;

  always @(posedge clk) begin
    if (eng.aes_start_o) m_cnt <= m_cnt + 1;
    else m_cnt <= 0;
    if (m_stale && eng.aes_start_o && eng.aes_valid_i) m_hold <= 3;
    else if (m_hold > 0) m_hold <= m_hold - 1;
  end

  assign eng.aes_valid_i = (m_en && eng.aes_start_o && m_cnt >= L)
                         || (m_hold > 0);
  assign eng.aes_ct_i = eng.aes_pt_o ^ eng.aes_state_o;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0] id;
    logic [127:0]  ct;
    logic [1:0]    err;
    int            t;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   grants[$];

  int checks = 0;
  int errors = 0;

  int m_ptr     = N - 1;
  int lat_next  = 7;
  bit to_mode   = 1'b0;
  bit reissue   = 1'b0;
  int rdy_delay = 0;
  int wcnt      = 0;
  int n_rsp     = 0;
  int stop_at   = 1 << 30;
  int start_cyc = 0;
  bit chk_key   = 1'b0;
  logic [1:0] key_exp = '0;
  bit prev_rv  = 1'b0;
  bit prev_rdy = 1'b0;
  logic [IW-1:0] h_id;
  logic [127:0]  h_ct;
  logic [1:0]    h_err;

  function automatic bit perm_ok(int i);
    logic [1:0] s;
    s = req_key[i*2 +: 2];
    if (s == 2'd3) s = 2'd2;
    return perm[i*3 + int'(s)];
  endfunction

  task automatic new_job(int i);
    req_pt[i*128 +: 128]    = {$urandom, $urandom, $urandom, $urandom};
    req_state[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cycle();
    int g;
    int e;
    logic [N-1:0] acc;
    exp_t x;
    exp_t f;
    acc = '0;
    @(negedge clk);
    if (req_ready != '0) begin
      g = -1;
      e = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      checks++;
      if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
        errors++;
        $display("FAIL grant_onehot ready=%b valid=%b", req_ready, req_valid);
      end
      for (int k = 1; k <= N; k++) begin
        if (e < 0 && req_valid[(m_ptr + k) % N]) e = (m_ptr + k) % N;
      end
      checks++;
      if (g != e) begin
        errors++;
        $display("FAIL grant_rr got=%0d exp=%0d", g, e);
      end
      m_ptr = g;
      acc[g] = 1'b1;
      grants.push_back(g);
      x.id  = IW'(g);
      x.err = !perm_ok(g) ? 2'd1 : (to_mode ? 2'd2 : 2'd0);
      x.ct  = (x.err == 2'd0)
            ? (req_pt[g*128 +: 128] ^ req_state[g*128 +: 128]) : '0;
      x.t   = cyc;
      x.lat = (x.err == 2'd1) ? 1 : (to_mode ? 0 : lat_next);
      sb.push_back(x);
    end
    if (chk_key && eng.aes_start_o) begin
      checks++;
      if (eng.aes_key_sel_o !== key_exp) begin
        errors++;
        $display("FAIL run_key_sel got=%0d exp=%0d", eng.aes_key_sel_o, key_exp);
      end
    end
    if (eng.aes_start_o) start_cyc++;
    if (rsp_valid) begin
      checks++;
      if (eng.aes_start_o !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL resp_quiet start=%b ready=%b", eng.aes_start_o, req_ready);
      end
      if (!prev_rv && sb.size() > 0 && sb[0].lat != 0) begin
        checks++;
        if (cyc - sb[0].t != sb[0].lat) begin
          errors++;
          $display("FAIL latency got=%0d exp=%0d", cyc - sb[0].t, sb[0].lat);
        end
      end
      if (prev_rv && !prev_rdy) begin
        checks++;
        if (rsp_id !== h_id || rsp_ct !== h_ct || rsp_err !== h_err) begin
          errors++;
          $display("FAIL resp_stable id=%0d err=%0d ct=%h", rsp_id, rsp_err, rsp_ct);
        end
      end
      h_id  = rsp_id;
      h_ct  = rsp_ct;
      h_err = rsp_err;
      if (rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected id=%0d err=%0d", rsp_id, rsp_err);
        end else begin
          f = sb.pop_front();
          if (rsp_id !== f.id || rsp_err !== f.err || rsp_ct !== f.ct) begin
            errors++;
            $display("FAIL resp_data id=%0d/%0d err=%0d/%0d ct=%h exp %h",
                     rsp_id, f.id, rsp_err, f.err, rsp_ct, f.ct);
          end
        end
        n_rsp++;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
    prev_rv  = rsp_valid;
    prev_rdy = rsp_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (reissue) new_job(i);
        else req_valid[i] = 1'b0;
      end
    end
    if (n_rsp >= stop_at) req_valid = '0;
    rsp_ready = rsp_valid && (wcnt >= rdy_delay);
  endtask

  task automatic wait_rsp(int n, int budget, string tag);
    int target;
    int k;
    target  = n_rsp + n;
    stop_at = target;
    k = 0;
    while (n_rsp < target && k < budget) begin
      cycle();
      k++;
    end
    checks++;
    if (n_rsp < target) begin
      errors++;
      $display("FAIL %s_timeout got=%0d exp=%0d responses", tag, n_rsp, target);
    end
    stop_at = 1 << 30;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0
        || rsp_id !== '0 || rsp_ct !== '0 || rsp_err !== '0
        || eng.aes_start_o !== 1'b0 || eng.aes_pt_o !== '0
        || eng.aes_state_o !== '0 || eng.aes_key_sel_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b rv=%b start=%b", busy, rsp_valid,
               eng.aes_start_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    perm = '1;
    req_pt[127:0]    = 128'h00112233445566778899aabbccddeeff;
    req_state[127:0] = '0;
    req_key[1:0]     = 2'd1;
    key_exp  = 2'd1;
    chk_key  = 1'b1;
    reissue  = 1'b0;
    lat_next = 7;
    start_cyc = 0;
    req_valid = 2'b01;
    wait_rsp(1, 40, "single");
    chk_key = 1'b0;
    checks++;
    if (start_cyc != L + 1) begin
      errors++;
      $display("FAIL single_run_len got=%0d exp=%0d", start_cyc, L + 1);
    end
  endtask

  task automatic test_permission();
    perm = 6'b000_011;
    req_key[3:2] = 2'd2;
    new_job(1);
    start_cyc = 0;
    req_valid = 2'b10;
    wait_rsp(1, 20, "perm");
    repeat (2) cycle();
    checks++;
    if (start_cyc != 0) begin
      errors++;
      $display("FAIL perm_start got=%0d exp=0", start_cyc);
    end
  endtask

  task automatic test_fairness();
    perm = '1;
    req_key = '0;
    new_job(0);
    new_job(1);
    reissue   = 1'b1;
    rdy_delay = 5;
    grants.delete();
    req_valid = 2'b11;
    wait_rsp(6, 300, "fair");
    reissue   = 1'b0;
    rdy_delay = 0;
    checks++;
    if (grants.size() != 6) begin
      errors++;
      $display("FAIL fair_count got=%0d exp=6", grants.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      checks++;
      if (grants[k] != k % 2) begin
        errors++;
        $display("FAIL fair_order slot=%0d got=%0d exp=%0d", k, grants[k], k % 2);
      end
    end
  endtask

  task automatic test_timeout();
    perm    = '1;
    m_en    = 1'b0;
    to_mode = 1'b1;
    new_job(0);
    req_valid = 2'b01;
    wait_rsp(1, 120, "tmo");
    m_en    = 1'b1;
    to_mode = 1'b0;
    new_job(0);
    req_valid = 2'b01;
    wait_rsp(1, 40, "after_tmo");
  endtask

  task automatic test_stale();
    int k;
    m_stale  = 1'b1;
    reissue  = 1'b1;
    lat_next = 7;
    grants.delete();
    new_job(0);
    req_valid = 2'b01;
    k = 0;
    while (grants.size() < 1 && k < 20) begin
      cycle();
      k++;
    end
    lat_next = 8;
    wait_rsp(2, 60, "stale");
    reissue  = 1'b0;
    m_stale  = 1'b0;
    lat_next = 7;
    repeat (5) cycle();
  endtask

  task automatic test_reset_mid();
    int k;
    start_cyc = 0;
    new_job(0);
    req_valid = 2'b01;
    k = 0;
    while (start_cyc == 0 && k < 20) begin
      cycle();
      k++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (eng.aes_start_o !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0
        || eng.aes_pt_o !== '0 || rsp_ct !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL midrst_outputs start=%b busy=%b rv=%b", eng.aes_start_o,
               busy, rsp_valid);
    end
    sb.delete();
    grants.delete();
    m_ptr   = N - 1;
    prev_rv = 1'b0;
    new_job(0);
    new_job(1);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL midrst_ready got=%b exp=00", req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_rsp(2, 60, "midrst");
    checks++;
    if (grants.size() == 0 || grants[0] != 0) begin
      errors++;
      $display("FAIL midrst_first_grant got=%0d exp=0",
               grants.size() ? grants[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_permission();
    test_fairness();
    test_timeout();
    test_stale();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
